// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game sequencer.
//   game_state_t : top-level sequencer states
//   BCD_W        : bits per BCD digit
//   BCD_DIGITS   : digits in the score counter
//   SCORE_MAX    : saturation value of the BCD score
package game_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } game_state_t;

   localparam int          BCD_W      = 4;
   localparam int          BCD_DIGITS = 4;
   localparam logic [15:0] SCORE_MAX  = 16'h9999;

endpackage

// File: rtl/game_ctrl_bcd_ctr.sv
// bcd_ctr: 4-digit saturating BCD incrementer.
//   clk   : system clock
//   reset : synchronous, active-high; clears the count
//   clr   : synchronous clear, wins over inc
//   inc   : add one (ignored once the count is 9999)
//   cnt   : registered BCD count
module bcd_ctr
   import game_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] cnt
);

   logic [15:0] cnt_q, cnt_d;

   // Next count: ripple a decimal carry from the least significant digit.
   always_comb begin
      logic             carry;
      logic [BCD_W-1:0] digit;
      cnt_d = cnt_q;
      carry = 1'b0;
      digit = '0;
      if (clr) begin
         cnt_d = 16'h0000;
      end else if (inc && (cnt_q != SCORE_MAX)) begin
         carry = 1'b1;
         for (int d = 0; d < BCD_DIGITS; d++) begin
            digit = cnt_q[d*BCD_W +: BCD_W];
            if (carry) begin
               if (digit == 4'd9) begin
                  cnt_d[d*BCD_W +: BCD_W] = 4'd0;
               end else begin
                  cnt_d[d*BCD_W +: BCD_W] = digit + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               cnt_d[d*BCD_W +: BCD_W] = digit;
            end
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 16'h0000;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game sequencer for the enemy subsystem.
//   clk, reset   : system clock, synchronous active-high reset
//   start_btn    : debounced start button level
//   killed       : one-cycle kill pulse from the enemy array
//   enemy_alive  : per-slot alive flags
//   enemy_y      : per-slot y position
//   start        : one-cycle game start pulse
//   gameover     : one-cycle game over pulse
//   playing      : high while a game is running
//   lives        : remaining lives
//   level        : difficulty level, saturating at N_LEVEL-1
//   score        : 4-digit BCD kill count, saturating at 9999
module game_ctrl
   import game_pkg::*;
#(
   parameter int N_ENEMY         = 8,
   parameter int Y_LIMIT         = 440,
   parameter int START_LIVES     = 3,
   parameter int KILLS_PER_LEVEL = 10,
   parameter int N_LEVEL         = 8,
   parameter int HOLD_TICKS      = 99_999_999
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start_btn,
   input  logic                       killed,
   input  logic [N_ENEMY-1:0]         enemy_alive,
   input  logic [8:0]                 enemy_y [N_ENEMY-1:0],
   output logic                       start,
   output logic                       gameover,
   output logic                       playing,
   output logic [2:0]                 lives,
   output logic [$clog2(N_LEVEL)-1:0] level,
   output logic [15:0]                score
);

   localparam int LW  = $clog2(N_LEVEL);
   localparam int KW  = (KILLS_PER_LEVEL > 1) ? $clog2(KILLS_PER_LEVEL) : 1;
   localparam int PCW = $clog2(N_ENEMY + 1);

   game_state_t          state_q, state_d;
   logic                 btn_q;
   logic                 start_q, start_d;
   logic                 over_q, over_d;
   logic                 play_q;
   logic [2:0]           lives_q, lives_d, lives_sub_s;
   logic [LW-1:0]        level_q, level_d;
   logic [KW-1:0]        kcnt_q, kcnt_d;
   logic [N_ENEMY-1:0]   br_q, br_d;
   logic [31:0]          hold_q, hold_d;
   logic [N_ENEMY-1:0]   br_s, nbr_s;
   logic [PCW-1:0]       pc_s [N_ENEMY+1];
   logic                 clr_s, inc_s;

   // Breach detection and running popcount of new breaches.
   assign pc_s[0] = '0;
   for (genvar i = 0; i < N_ENEMY; i++) begin : g_breach
      assign br_s[i]    = enemy_alive[i] & (enemy_y[i] >= 9'(Y_LIMIT));
      assign nbr_s[i]   = br_s[i] & ~br_q[i];
      assign pc_s[i+1]  = pc_s[i] + PCW'(nbr_s[i]);
   end

   // Lives after this cycle's new breaches, floored at zero.
   always_comb begin
      if (32'(lives_q) > 32'(pc_s[N_ENEMY])) begin
         lives_sub_s = lives_q - 3'(pc_s[N_ENEMY]);
      end else begin
         lives_sub_s = 3'd0;
      end
   end

   // Sequencer next-state and counter updates.
   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      over_d  = 1'b0;
      lives_d = lives_q;
      level_d = level_q;
      kcnt_d  = kcnt_q;
      br_d    = br_q & enemy_alive;
      hold_d  = hold_q;
      clr_s   = 1'b0;
      inc_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_btn & ~btn_q) begin
               state_d = S_PLAY;
               start_d = 1'b1;
               lives_d = 3'(START_LIVES);
               level_d = '0;
               kcnt_d  = '0;
               br_d    = '0;
               clr_s   = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PLAY: begin
            // An enemy stays flagged while alive so it costs one life per descent.
            br_d    = (br_q | br_s) & enemy_alive;
            lives_d = lives_sub_s;
            if (killed) begin
               inc_s = 1'b1;
               if (kcnt_q == KW'(KILLS_PER_LEVEL - 1)) begin
                  kcnt_d = '0;
                  if (level_q != LW'(N_LEVEL - 1)) begin
                     level_d = level_q + 1'b1;
                  end else begin
                     level_d = level_q;
                  end
               end else begin
                  kcnt_d = kcnt_q + 1'b1;
               end
            end else begin
               inc_s = 1'b0;
            end
            if (lives_sub_s == 3'd0) begin
               state_d = S_OVER;
               over_d  = 1'b1;
               hold_d  = 32'(HOLD_TICKS);
            end else begin
               state_d = S_PLAY;
            end
         end
         S_OVER: begin
            if (hold_q == 32'd0) begin
               state_d = S_IDLE;
            end else begin
               hold_d = hold_q - 32'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         btn_q   <= 1'b0;
         start_q <= 1'b0;
         over_q  <= 1'b0;
         play_q  <= 1'b0;
         lives_q <= 3'd0;
         level_q <= '0;
         kcnt_q  <= '0;
         br_q    <= '0;
         hold_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         btn_q   <= start_btn;
         start_q <= start_d;
         over_q  <= over_d;
         play_q  <= (state_d == S_PLAY);
         lives_q <= lives_d;
         level_q <= level_d;
         kcnt_q  <= kcnt_d;
         br_q    <= br_d;
         hold_q  <= hold_d;
      end
   end

   bcd_ctr u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_s),
      .inc   (inc_s),
      .cnt   (score)
   );

   assign start    = start_q;
   assign gameover = over_q;
   assign playing  = play_q;
   assign lives    = lives_q;
   assign level    = level_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: self-checking bench for game_ctrl against a behavioural model.
module tb_game_ctrl;

   localparam int NE   = 8;
   localparam int YL   = 440;
   localparam int SL   = 3;
   localparam int KPL  = 10;
   localparam int NL   = 8;
   localparam int HOLD = 5;

   logic          clk = 1'b0;
   logic          reset, start_btn, killed;
   logic [NE-1:0] enemy_alive;
   logic [8:0]    enemy_y [NE-1:0];
   logic          start, gameover, playing;
   logic [2:0]    lives;
   logic [2:0]    level;
   logic [15:0]   score;

   int errors = 0;
   int checks = 0;

   // Model: 0 idle, 1 play, 2 over; score kept as a plain integer.
   int m_mode = 0, m_hold = 0, m_lives = 0, m_level = 0, m_kills = 0, m_score = 0;
   bit m_prev = 1'b0, m_start = 1'b0, m_go = 1'b0;
   bit m_charged [NE];

   game_ctrl #(
      .N_ENEMY(NE), .Y_LIMIT(YL), .START_LIVES(SL),
      .KILLS_PER_LEVEL(KPL), .N_LEVEL(NL), .HOLD_TICKS(HOLD)
   ) dut (
      .clk(clk), .reset(reset), .start_btn(start_btn), .killed(killed),
      .enemy_alive(enemy_alive), .enemy_y(enemy_y),
      .start(start), .gameover(gameover), .playing(playing),
      .lives(lives), .level(level), .score(score)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // One clock of the game rules, applied to the inputs currently driven.
   task automatic model_step();
      int lost;
      bit hit;
      m_start = 1'b0;
      m_go    = 1'b0;
      if (reset) begin
         m_mode = 0; m_hold = 0; m_lives = 0; m_level = 0; m_kills = 0; m_score = 0;
         m_prev = 1'b0;
         for (int i = 0; i < NE; i++) m_charged[i] = 1'b0;
         return;
      end
      if (m_mode == 0) begin
         for (int i = 0; i < NE; i++) if (!enemy_alive[i]) m_charged[i] = 1'b0;
         if (start_btn && !m_prev) begin
            m_mode = 1; m_start = 1'b1;
            m_score = 0; m_lives = SL; m_level = 0; m_kills = 0;
            for (int i = 0; i < NE; i++) m_charged[i] = 1'b0;
         end
      end else if (m_mode == 1) begin
         lost = 0;
         for (int i = 0; i < NE; i++) begin
            hit = enemy_alive[i] && (int'(enemy_y[i]) >= YL);
            if (hit && !m_charged[i]) lost++;
            if (!enemy_alive[i]) m_charged[i] = 1'b0;
            else if (hit) m_charged[i] = 1'b1;
         end
         m_lives = (m_lives > lost) ? m_lives - lost : 0;
         if (killed) begin
            if (m_score < 9999) m_score++;
            m_kills++;
            if (m_kills == KPL) begin
               m_kills = 0;
               if (m_level < NL - 1) m_level++;
            end
         end
         if (m_lives == 0) begin
            m_mode = 2; m_go = 1'b1; m_hold = HOLD;
         end
      end else begin
         for (int i = 0; i < NE; i++) if (!enemy_alive[i]) m_charged[i] = 1'b0;
         if (m_hold == 0) m_mode = 0;
         else m_hold--;
      end
      m_prev = start_btn;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk("start",    32'(start),    32'(m_start));
      chk("gameover", 32'(gameover), 32'(m_go));
      chk("playing",  32'(playing),  32'(m_mode == 1));
      chk("lives",    32'(lives),    32'(m_lives));
      chk("level",    32'(level),    32'(m_level));
      chk("score",    32'(score),    32'(to_bcd(m_score)));
   endtask

   task automatic quiet_enemies();
      killed = 1'b0;
      enemy_alive = '0;
      for (int i = 0; i < NE; i++) enemy_y[i] = 9'd0;
   endtask

   initial begin
      int guard;
      logic [7:0] pat;
      reset = 1'b1; start_btn = 1'b0;
      quiet_enemies();
      cyc(); cyc();
      chk("rst_lives", 32'(lives), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      reset = 1'b0;
      cyc();

      // Start edge, then a long press must not restart.
      start_btn = 1'b1;
      cyc();
      chk("start_pulse", 32'(start), 32'd1);
      chk("start_lives", 32'(lives), 32'd3);
      repeat (100) cyc();
      start_btn = 1'b0;
      cyc();

      // Twelve kills cross one level step.
      repeat (12) begin
         killed = 1'b1; cyc();
         killed = 1'b0; cyc();
      end
      chk("score12", 32'(score), 32'h0012);
      chk("level1",  32'(level), 32'd1);

      // One descent costs one life; a respawn costs another.
      enemy_alive[2] = 1'b1; enemy_y[2] = 9'd450;
      repeat (50) cyc();
      chk("lives_once", 32'(lives), 32'd2);
      enemy_alive[2] = 1'b0; cyc(); cyc();
      enemy_alive[2] = 1'b1; cyc();
      chk("lives_respawn", 32'(lives), 32'd1);
      enemy_alive[2] = 1'b0; cyc();

      // Run the score up to saturation.
      killed = 1'b1;
      guard = 0;
      while (m_score < 9998 && guard < 12000) begin
         cyc();
         guard++;
      end
      chk("sat_reach", 32'(guard < 12000), 32'd1);
      repeat (3) cyc();
      killed = 1'b0;
      cyc();
      chk("score_sat", 32'(score), 32'h9999);
      chk("level_sat", 32'(level), 32'd7);

      // Random play: breaches, kills, button toggles, restarts.
      enemy_alive = '0;
      repeat (600) begin
         if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
         killed = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < NE; i++) begin
            if ($urandom_range(0, 15) == 0) enemy_alive[i] = ~enemy_alive[i];
            enemy_y[i] = 9'($urandom_range(425, 455));
         end
         cyc();
      end

      reset = 1'b1; start_btn = 1'b0;
      quiet_enemies();
      cyc();
      reset = 1'b0;
      cyc();

      // Two simultaneous breaches end the game; the coincident kill still scores.
      start_btn = 1'b1; cyc();
      start_btn = 1'b0; cyc();
      enemy_alive[1] = 1'b1; enemy_y[1] = 9'd450;
      cyc();
      chk("lives2", 32'(lives), 32'd2);
      enemy_alive[0] = 1'b1; enemy_y[0] = 9'd445;
      enemy_alive[5] = 1'b1; enemy_y[5] = 9'd440;
      killed = 1'b1;
      cyc();
      chk("go_lives",   32'(lives),    32'd0);
      chk("go_pulse",   32'(gameover), 32'd1);
      chk("go_playing", 32'(playing),  32'd0);
      chk("go_score",   32'(score),    32'h0001);
      quiet_enemies();

      // Hold interval: edges during S_OVER are ignored, the first one after is taken.
      pat = 8'b1010_0010;
      for (int k = 1; k <= 8; k++) begin
         start_btn = pat[k-1];
         cyc();
         if (k == 1) chk("go_low", 32'(gameover), 32'd0);
         if (k < 8) chk("hold_nostart", 32'(start), 32'd0);
      end
      chk("restart_pulse", 32'(start),   32'd1);
      chk("restart_score", 32'(score),   32'h0000);
      chk("restart_play",  32'(playing), 32'd1);
      start_btn = 1'b0;
      cyc();

      // Reset in the middle of a game.
      repeat (7) begin
         killed = 1'b1; cyc();
         killed = 1'b0; cyc();
      end
      enemy_alive[3] = 1'b1; enemy_y[3] = 9'd450;
      cyc();
      chk("mid_score", 32'(score), 32'h0007);
      chk("mid_lives", 32'(lives), 32'd2);
      reset = 1'b1; killed = 1'b1; enemy_alive[4] = 1'b1; enemy_y[4] = 9'd460;
      cyc();
      chk("mid_rst_start", 32'(start),    32'd0);
      chk("mid_rst_go",    32'(gameover), 32'd0);
      chk("mid_rst_play",  32'(playing),  32'd0);
      chk("mid_rst_lives", 32'(lives),    32'd0);
      chk("mid_rst_score", 32'(score),    32'd0);
      reset = 1'b0;
      quiet_enemies();
      cyc(); cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
